// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
//
// Purpose:
//   Grants one transaction at a time to either the instruction-fetch channel or
//   the load/store channel, drives the shared memory port with a registered copy
//   of the granted request, forwards the request ack to the owner and routes the
//   read response back to it. At most one transaction is outstanding.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   PC, Inst_Req_Valid        fetch request in;  Inst_Req_Ack out
//   Instruction, Inst_Valid   fetch response out; Inst_Ack in
//   Address, MemWrite,        load/store request in; Mem_Req_Ack out
//   Write_data, Write_strb,
//   MemRead
//   Read_data,                load response out; Read_data_Ack in
//   Read_data_Valid
//   mem_addr, mem_wen,        shared-port request out; mem_req_ack in
//   mem_wdata, mem_wstrb,
//   mem_ren
//   mem_rdata,                shared-port response in; mem_rdata_ack out
//   mem_rdata_valid
//   arb_perf_cnt_0..3         performance counters
//
// Configuration:
//   MEM_ARB_PERF_CNT_EN  when defined, builds four wrapping CNT_W counters
//                        (fetch grants, load/store grants, fetch wait cycles,
//                        load/store wait cycles); otherwise they read 0.

module mips_mem_arbiter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PC,
  input  logic             Inst_Req_Valid,
  output logic             Inst_Req_Ack,
  output logic [31:0]      Instruction,
  output logic             Inst_Valid,
  input  logic             Inst_Ack,
  input  logic [31:0]      Address,
  input  logic             MemWrite,
  input  logic [31:0]      Write_data,
  input  logic [3:0]       Write_strb,
  input  logic             MemRead,
  output logic             Mem_Req_Ack,
  output logic [31:0]      Read_data,
  output logic             Read_data_Valid,
  input  logic             Read_data_Ack,
  output logic [31:0]      mem_addr,
  output logic             mem_wen,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  output logic             mem_ren,
  input  logic             mem_req_ack,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_rdata_valid,
  output logic             mem_rdata_ack,
  output logic [CNT_W-1:0] arb_perf_cnt_0,
  output logic [CNT_W-1:0] arb_perf_cnt_1,
  output logic [CNT_W-1:0] arb_perf_cnt_2,
  output logic [CNT_W-1:0] arb_perf_cnt_3
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_I_REQ = 3'd1;
  localparam logic [2:0] ST_I_RSP = 3'd2;
  localparam logic [2:0] ST_D_WR  = 3'd3;
  localparam logic [2:0] ST_D_RD  = 3'd4;
  localparam logic [2:0] ST_D_RSP = 3'd5;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  logic [2:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wen_q, wen_d;
  logic        ren_q, ren_d;

  logic inst_pend;
  logic data_pend;
  logic grant_inst;
  logic grant_data;

  logic in_i_req;
  logic in_d_req;
  logic in_i_rsp;
  logic in_d_rsp;

  assign inst_pend = Inst_Req_Valid;
  assign data_pend = MemRead | MemWrite;

  assign in_i_req = (state_q == ST_I_REQ);
  assign in_d_req = (state_q == ST_D_WR) || (state_q == ST_D_RD);
  assign in_i_rsp = (state_q == ST_I_RSP);
  assign in_d_rsp = (state_q == ST_D_RSP);

  // Arbitration only happens in IDLE. On contention the side that did not win
  // last time is granted; with a single requester it simply wins.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (state_q == ST_IDLE) begin
      if (inst_pend && (!data_pend || (last_grant_q == GRANT_DATA))) begin
        grant_inst = 1'b1;
      end else if (data_pend) begin
        grant_data = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    wen_d        = wen_q;
    ren_d        = ren_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_inst) begin
          state_d      = ST_I_REQ;
          last_grant_d = GRANT_INST;
          addr_d       = PC;
          wdata_d      = 32'h0;
          wstrb_d      = 4'h0;
          wen_d        = 1'b0;
          ren_d        = 1'b1;
        end else if (grant_data) begin
          last_grant_d = GRANT_DATA;
          addr_d       = Address;
          // MemRead together with MemWrite is treated as a write.
          if (MemWrite) begin
            state_d = ST_D_WR;
            wdata_d = Write_data;
            wstrb_d = Write_strb;
            wen_d   = 1'b1;
            ren_d   = 1'b0;
          end else begin
            state_d = ST_D_RD;
            wdata_d = 32'h0;
            wstrb_d = 4'h0;
            wen_d   = 1'b0;
            ren_d   = 1'b1;
          end
        end
      end

      ST_I_REQ: begin
        if (mem_req_ack) begin
          state_d = ST_I_RSP;
          wen_d   = 1'b0;
          ren_d   = 1'b0;
        end
      end

      ST_D_WR: begin
        // Stores have no response phase.
        if (mem_req_ack) begin
          state_d = ST_IDLE;
          wen_d   = 1'b0;
          ren_d   = 1'b0;
        end
      end

      ST_D_RD: begin
        if (mem_req_ack) begin
          state_d = ST_D_RSP;
          wen_d   = 1'b0;
          ren_d   = 1'b0;
        end
      end

      ST_I_RSP: begin
        if (mem_rdata_valid && Inst_Ack) begin
          state_d = ST_IDLE;
        end
      end

      ST_D_RSP: begin
        if (mem_rdata_valid && Read_data_Ack) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_DATA;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 4'h0;
      wen_q        <= 1'b0;
      ren_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      wen_q        <= wen_d;
      ren_q        <= ren_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wen   = wen_q;
  assign mem_ren   = ren_q;

  // Acks and responses are steered by state only, so the non-owner always
  // sees 0 and stray mem_rdata_valid outside a response phase is dropped.
  assign Inst_Req_Ack    = in_i_req & mem_req_ack;
  assign Mem_Req_Ack     = in_d_req & mem_req_ack;
  assign Instruction     = in_i_rsp ? mem_rdata : 32'h0;
  assign Inst_Valid      = in_i_rsp & mem_rdata_valid;
  assign Read_data       = in_d_rsp ? mem_rdata : 32'h0;
  assign Read_data_Valid = in_d_rsp & mem_rdata_valid;
  assign mem_rdata_ack   = (in_i_rsp & Inst_Ack) | (in_d_rsp & Read_data_Ack);

`ifdef MEM_ARB_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_0_q;
  logic [CNT_W-1:0] cnt_1_q;
  logic [CNT_W-1:0] cnt_2_q;
  logic [CNT_W-1:0] cnt_3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_0_q <= '0;
      cnt_1_q <= '0;
      cnt_2_q <= '0;
      cnt_3_q <= '0;
    end else begin
      if (grant_inst) begin
        cnt_0_q <= cnt_0_q + CNT_ONE;
      end
      if (grant_data) begin
        cnt_1_q <= cnt_1_q + CNT_ONE;
      end
      if (inst_pend && !in_i_req) begin
        cnt_2_q <= cnt_2_q + CNT_ONE;
      end
      if (data_pend && !in_d_req) begin
        cnt_3_q <= cnt_3_q + CNT_ONE;
      end
    end
  end

  assign arb_perf_cnt_0 = cnt_0_q;
  assign arb_perf_cnt_1 = cnt_1_q;
  assign arb_perf_cnt_2 = cnt_2_q;
  assign arb_perf_cnt_3 = cnt_3_q;
`else
  assign arb_perf_cnt_0 = '0;
  assign arb_perf_cnt_1 = '0;
  assign arb_perf_cnt_2 = '0;
  assign arb_perf_cnt_3 = '0;
`endif

endmodule
